// File: rtl/mem32_pkg.sv
// Shared types and helpers for the mem32 byte-stream loader.
// The check-bit helper is only referenced when MEM32_LOADER_PARITY_EN is defined.
package mem32_pkg;

  localparam int WORD_W  = 32;
  localparam int STORE_W = 36;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Even parity per byte: bit k covers word[8k+7:8k].
  function automatic logic [3:0] byte_parity(input logic [WORD_W-1:0] word);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) begin
      p[k] = ^word[8*k +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/mem32_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to a memory.
// Optional per-byte check bits in o_wdata[35:32] when MEM32_LOADER_PARITY_EN is defined.
module mem32_loader
  import mem32_pkg::*;
#(
  parameter  int DEPTH      = 512,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [STORE_W-1:0]    o_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                state;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [WORD_W-1:0]     word_q;
  logic                  we_q;
  logic [WORD_W-1:0]     full_word;
  logic [3:0]            check_bits;

  // The fourth byte goes straight into the stored word, saving a cycle per word.
  assign full_word = {i_byte, word_q[23:0]};

`ifdef MEM32_LOADER_PARITY_EN
  assign check_bits = byte_parity(full_word);
`else
  assign check_bits = 4'b0000;
`endif

  // An abort landing on the WRITE cycle must kill the strobe in that same cycle.
  assign o_we = we_q && !i_abort;

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values; reset clears the assembled word too, not just control state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      byte_idx     <= '0;
      addr_q       <= '0;
      remaining_q  <= '0;
      word_q       <= '0;
      we_q         <= 1'b0;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
    end else begin
      we_q   <= 1'b0;
      o_done <= 1'b0;
      if (i_abort && (state == ST_COLLECT || state == ST_WRITE)) begin
        state        <= ST_IDLE;
        byte_idx     <= '0;
        word_q       <= '0;
        o_byte_ready <= 1'b0;
        o_busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              addr_q      <= i_base_addr;
              remaining_q <= i_num_words;
              byte_idx    <= '0;
              word_q      <= '0;
              if (i_num_words == '0) begin
                state  <= ST_DONE;
                o_done <= 1'b1;
              end else begin
                state        <= ST_COLLECT;
                o_byte_ready <= 1'b1;
                o_busy       <= 1'b1;
              end
            end
          end
          ST_COLLECT: begin
            if (i_byte_valid && o_byte_ready) begin
              if (byte_idx == 2'd3) begin
                state        <= ST_WRITE;
                we_q         <= 1'b1;
                o_waddr      <= addr_q;
                o_wdata      <= {check_bits, full_word};
                o_byte_ready <= 1'b0;
                byte_idx     <= '0;
                word_q       <= '0;
              end else begin
                word_q[{byte_idx, 3'b000} +: 8] <= i_byte;
                byte_idx                        <= byte_idx + 2'd1;
              end
            end
          end
          ST_WRITE: begin
            addr_q      <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state        <= ST_COLLECT;
              o_byte_ready <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mem32_loader.md
MEM32_LOADER -- requirements
Module: mem32_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 512, words in target memory.
REQ-002 SHALL have localparam ADDR_WIDTH, value $clog2(DEPTH), address width.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_start  input  1  load-start pulse.
REQ-006 SHALL have port i_abort  input  1  abandon current load.
REQ-007 SHALL have port i_base_addr  input  ADDR_WIDTH  first word address.
REQ-008 SHALL have port i_num_words  input  ADDR_WIDTH+1  words to load (0..DEPTH).
REQ-009 SHALL have port i_byte_valid  input  1  byte-stream valid.
REQ-010 SHALL have port i_byte  input  8  byte-stream data.
REQ-011 SHALL have port o_byte_ready  output  1  byte-stream ready.
REQ-012 SHALL have port o_we  output  1  memory write enable.
REQ-013 SHALL have port o_waddr  output  ADDR_WIDTH  memory write address.
REQ-014 SHALL have port o_wdata  output  36  storage word: [31:0] data, [35:32] check bits.
REQ-015 SHALL have port o_busy  output  1  load in progress.
REQ-016 SHALL have port o_done  output  1  one-cycle load-complete pulse.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: i_start=1 SHALL latch i_base_addr into the address counter and i_num_words into the remaining counter, then go to COLLECT, or to DONE if i_num_words=0.
REQ-019 i_start SHALL be ignored outside IDLE.
REQ-020 o_byte_ready SHALL be 1 only in COLLECT; a byte transfers when i_byte_valid and o_byte_ready are both 1.
REQ-021 Bytes SHALL assemble little-endian: first byte to [7:0], fourth to [31:24], via a 2-bit byte index.
REQ-022 The cycle after the fourth transfer SHALL be WRITE: o_we=1 for exactly one cycle, o_waddr=current address, o_wdata=assembled word.
REQ-023 After WRITE the address SHALL increment modulo DEPTH (DEPTH-1 wraps to 0) and remaining SHALL decrement; state SHALL go to DONE if remaining becomes 0, else to COLLECT.
REQ-024 DONE SHALL assert o_done for one cycle and then return to IDLE.
REQ-025 o_busy SHALL be 1 in COLLECT and WRITE, 0 in IDLE and DONE.
REQ-026 Sustained throughput SHALL be one word per 5 cycles when i_byte_valid stays high; stalls on i_byte_valid=0 SHALL hold the byte index and partial word.
REQ-027 i_abort=1 in COLLECT or WRITE SHALL go to IDLE next cycle, discard the partial word, suppress o_we that cycle, and not pulse o_done; i_abort SHALL have priority over every other event.
REQ-028 o_we SHALL be 0 in every state except WRITE.

Reset
REQ-029 i_rst_n=0 SHALL asynchronously force IDLE and clear the byte index, counters and assembled word, and set o_we, o_byte_ready, o_busy and o_done to 0, and o_waddr and o_wdata to 0.
REQ-030 Reset mid-load SHALL discard all progress; no write SHALL issue until a new i_start.

Configuration
REQ-031 Macro MEM32_LOADER_PARITY_EN defined: o_wdata[32+k] SHALL be the even parity (XOR) of byte k of o_wdata[31:0], k=0..3.
REQ-032 Macro MEM32_LOADER_PARITY_EN undefined: o_wdata[35:32] SHALL be 4'b0000 and no parity logic SHALL be present.

Structure
REQ-033 A shared package mem32_pkg SHALL hold the state enum, WORD_W=32, STORE_W=36, and a byte-parity function.
REQ-034 The design SHALL be a single module with no sub-modules.

Verification
REQ-035 Verification SHALL cover: base=0x010, n=2, bytes 11 22 33 44 55 66 77 88 -> writes addr 0x010 data 0x44332211, addr 0x011 data 0x88776655, then one o_done pulse.
REQ-036 Verification SHALL cover: DEPTH=512, base=0x1FF, n=2 -> writes at 0x1FF then 0x000.
REQ-037 Verification SHALL cover: n=0 -> no o_we, o_byte_ready stays 0, o_done one cycle after start.
REQ-038 Verification SHALL cover: abort after 2 bytes, then restart base=0x020 n=1 with bytes AA BB CC DD -> single write 0xDDCCBBAA at 0x020, no stale bytes.
REQ-039 Verification SHALL cover: with PARITY_EN, data 0x0100FF07 -> o_wdata[35:32]=4'b1001; without PARITY_EN -> 4'b0000.
REQ-040 Verification SHALL cover: reset asserted mid-COLLECT -> outputs 0 immediately; the next load writes correctly from its own base.
